// File: rtl/fp32_sc_multiplier.sv
// IEEE-754 single multiplier; fraction cross-term fa*fb estimated by an LFSR/AND stochastic stream.
// Define SC_MULT_EXACT_EN to compute the cross-term exactly at LOAD (same latency, golden mode).
module fp32_sc_multiplier #(
    parameter int unsigned SC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] P,
    output logic        done
);
    localparam int unsigned N        = SC_BITS;
    localparam int unsigned MW       = N + 2;
    localparam int unsigned RUN_LAST = (1 << N) - 2;

    typedef logic [N-1:0]   frac_t;
    typedef logic [MW-1:0]  msum_t;
`ifdef SC_MULT_EXACT_EN
    typedef logic [2*N-1:0] wide_t;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_FINISH,
        S_DONE
    } state_t;

    state_t     state;
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic       a_fnz, b_fnz;
    frac_t      fa_q, fb_q;
    frac_t      cnt;
    frac_t      c;

`ifndef SC_MULT_EXACT_EN
    // Maximal-length Fibonacci tap masks (bit k-1 set for tap k)
    function automatic logic [15:0] tap_mask(input int unsigned n);
        case (n)
            4:       tap_mask = 16'h000C;
            5:       tap_mask = 16'h0014;
            6:       tap_mask = 16'h0030;
            7:       tap_mask = 16'h0060;
            8:       tap_mask = 16'h00B8;
            9:       tap_mask = 16'h0110;
            10:      tap_mask = 16'h0240;
            11:      tap_mask = 16'h0500;
            12:      tap_mask = 16'h0829;
            13:      tap_mask = 16'h100D;
            14:      tap_mask = 16'h2015;
            15:      tap_mask = 16'h6000;
            16:      tap_mask = 16'hD008;
            default: tap_mask = 16'h00B8;
        endcase
    endfunction

    localparam frac_t TAPS  = frac_t'(tap_mask(N));
    localparam frac_t SEED1 = frac_t'(1);
    localparam frac_t SEED2 = frac_t'((1 << (N - 1)) + 1);

    frac_t lfsr1, lfsr2;
    logic  sc_bit;

    assign sc_bit = (fa_q > lfsr1) & (fb_q > lfsr2);
`endif

    // Result assembly from registered operand fields and the cross-term count
    msum_t            m_sum, m_norm;
    logic signed [10:0] e_res;
    logic [22:0]      frac_res;
    logic             s_res;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]      p_next;

    always_comb begin
        m_sum    = (msum_t'(1) << N) + msum_t'(fa_q) + msum_t'(fb_q) + msum_t'(c);
        m_norm   = m_sum;
        e_res    = $signed(11'(ea)) + $signed(11'(eb)) - 11'sd127;
        if (m_sum[MW-1]) begin
            m_norm = m_sum >> 1;
            e_res  = e_res + 11'sd1;
        end
        frac_res = 23'(m_norm - (msum_t'(1) << N)) << (23 - N);
        s_res    = sa ^ sb;
        a_nan    = (ea == 8'hFF) && a_fnz;
        b_nan    = (eb == 8'hFF) && b_fnz;
        a_inf    = (ea == 8'hFF) && !a_fnz;
        b_inf    = (eb == 8'hFF) && !b_fnz;
        a_zero   = (ea == 8'h00);
        b_zero   = (eb == 8'h00);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_next = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            p_next = {s_res, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            p_next = {s_res, 31'd0};
        end else if (e_res >= 11'sd255) begin
            p_next = {s_res, 8'hFF, 23'd0};
        end else if (e_res <= 11'sd0) begin
            p_next = {s_res, 31'd0};
        end else begin
            p_next = {s_res, e_res[7:0], frac_res};
        end
    end

    // Control FSM with registered product and done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
            P     <= '0;
            done  <= 1'b0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            ea    <= '0;
            eb    <= '0;
            a_fnz <= 1'b0;
            b_fnz <= 1'b0;
            fa_q  <= '0;
            fb_q  <= '0;
            cnt   <= '0;
            c     <= '0;
`ifndef SC_MULT_EXACT_EN
            lfsr1 <= SEED1;
            lfsr2 <= SEED2;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    sa    <= A[31];
                    sb    <= B[31];
                    ea    <= A[30:23];
                    eb    <= B[30:23];
                    a_fnz <= |A[22:0];
                    b_fnz <= |B[22:0];
                    fa_q  <= A[22 -: N];
                    fb_q  <= B[22 -: N];
                    cnt   <= '0;
`ifdef SC_MULT_EXACT_EN
                    c     <= frac_t'((wide_t'(A[22 -: N]) * wide_t'(B[22 -: N])) >> N);
`else
                    c     <= '0;
`endif
                    state <= S_RUN;
                end
                S_RUN: begin
`ifndef SC_MULT_EXACT_EN
                    lfsr1 <= {lfsr1[N-2:0], ^(lfsr1 & TAPS)};
                    lfsr2 <= {lfsr2[N-2:0], ^(lfsr2 & TAPS)};
                    c     <= c + frac_t'(sc_bit);
`endif
                    cnt   <= cnt + frac_t'(1);
                    if (cnt == frac_t'(RUN_LAST)) begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    P     <= p_next;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_sc_multiplier.sv
// Self-checking bench for fp32_sc_multiplier: directed cases, latency, reset abort, randomized range checks.
module tb_fp32_sc_multiplier;
    localparam int unsigned N   = 8;
    localparam int          CYC = (1 << N) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] A   = '0;
    logic [31:0] B   = '0;
    logic [31:0] P;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    fp32_sc_multiplier #(.SC_BITS(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .P    (P),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference product from the arithmetic rules, for a given cross-term count c
    function automatic logic [31:0] ref_p(input logic [31:0] a, input logic [31:0] b, input int c);
        int  ea = int'(a[30:23]);
        int  eb = int'(b[30:23]);
        int  fa = int'(a[22 -: N]);
        int  fb = int'(b[22 -: N]);
        bit  s  = a[31] ^ b[31];
        bit  an = (ea == 255) && (a[22:0] != 0);
        bit  bn = (eb == 255) && (b[22:0] != 0);
        bit  ai = (ea == 255) && (a[22:0] == 0);
        bit  bi = (eb == 255) && (b[22:0] == 0);
        bit  az = (ea == 0);
        bit  bz = (eb == 0);
        int  m, e;
        if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        m = (1 << N) + fa + fb + c;
        e = ea + eb - 127;
        if (m >= (1 << (N + 1))) begin
            m = m / 2;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'((m - (1 << N)) << (23 - N))};
    endfunction

    // Admissible cross-term counts: exact in golden mode; stream bounds otherwise
    function automatic void c_range(input logic [31:0] a, input logic [31:0] b, output int lo, output int hi);
        int fa = int'(a[22 -: N]);
        int fb = int'(b[22 -: N]);
`ifdef SC_MULT_EXACT_EN
        lo = (fa * fb) >> N;
        hi = lo;
`else
        if (fa == 0 || fb == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            hi = ((fa < fb) ? fa : fb) - 1;
            lo = fa + fb - 2 - ((1 << N) - 1);
            if (lo < 0) lo = 0;
        end
`endif
    endfunction

    function automatic real fp_val(input logic [31:0] p);
        return (1.0 + real'(p[22:0]) / 8388608.0) * (2.0 ** (real'(int'(p[30:23])) - 127.0));
    endfunction

    // Holds rst low, loads operands, releases and checks the exact done latency
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, output logic [31:0] p);
        @(negedge clk);
        rst = 1'b0;
        A   = a;
        B   = b;
        @(negedge clk);
        check("rst_p", P, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= CYC; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                A = $urandom;
                B = $urandom;
            end
            if (k == CYC - 1) check("done_early", 32'(done), 32'd0);
        end
        check("done_edge", 32'(done), 32'd1);
        p = P;
    endtask

    task automatic check_range(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        int lo, hi;
        logic [31:0] plo, phi;
        bit ok;
        c_range(a, b, lo, hi);
        plo = ref_p(a, b, lo);
        phi = ref_p(a, b, hi);
        ok  = (p[31] == plo[31]) && (p[30:0] >= plo[30:0]) && (p[30:0] <= phi[30:0]);
        n_vec++;
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s: A=%h B=%h observed %h expected %h..%h", tag, a, b, p, plo, phi);
        end
    endtask

    initial begin
        logic [31:0] p, a, b;
        int  s, e, f;
        real v, err;

        repeat (3) @(negedge clk);
        check("reset_p", P, 32'd0);
        check("reset_done", 32'(done), 32'd0);

        start_and_wait(32'h4000_0000, 32'h4040_0000, p);
        check("mul_2x3", p, 32'h40C0_0000);
        repeat (4) @(posedge clk);
        #1;
        check("hold_p", P, 32'h40C0_0000);
        check("hold_done", 32'(done), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_clr_p", P, 32'd0);
        check("async_clr_done", 32'(done), 32'd0);

        start_and_wait(32'hC000_0000, 32'h4040_0000, p);
        check("mul_neg", p, 32'hC0C0_0000);

        start_and_wait(32'h3FC0_0000, 32'h3FC0_0000, p);
`ifdef SC_MULT_EXACT_EN
        check("mul_1p5sq", p, 32'h4010_0000);
`else
        v   = fp_val(p);
        err = (v > 2.25) ? (v - 2.25) / 2.25 : (2.25 - v) / 2.25;
        check("mul_1p5sq_tol", 32'(err < 0.02), 32'd1);
        check("mul_1p5sq_exp", 32'(p[31:23]), 32'h080);
`endif

        start_and_wait(32'h4480_038D, 32'h4480_0712, p);
        check("mul_1024", p, 32'h4980_0000);
        start_and_wait(32'h7F00_0000, 32'h7F00_0000, p);
        check("ovf_inf", p, 32'h7F80_0000);
        start_and_wait(32'h0000_0000, 32'h3FC0_0000, p);
        check("zero", p, 32'h0000_0000);
        start_and_wait(32'h7FC0_0000, 32'h3F80_0000, p);
        check("nan", p, 32'h7FC0_0000);
        start_and_wait(32'h7F80_0000, 32'h0000_0000, p);
        check("inf_x_zero", p, 32'h7FC0_0000);
        start_and_wait(32'hFF80_0000, 32'h4000_0000, p);
        check("inf_x_fin", p, 32'hFF80_0000);
        start_and_wait(32'h0080_0000, 32'h0080_0000, p);
        check("underflow", p, 32'h0000_0000);
        start_and_wait(32'h8000_0000, 32'h3F80_0000, p);
        check("neg_zero", p, 32'h8000_0000);

        // Abort at edge 100, then a fresh multiply must keep the full latency
        @(negedge clk);
        rst = 1'b0;
        A   = 32'h3FC0_0000;
        B   = 32'h3FC0_0000;
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("abort_pre_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_p", P, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        start_and_wait(32'hC000_0000, 32'h4040_0000, p);
        check("after_abort", p, 32'hC0C0_0000);

        for (int i = 0; i < 24; i++) begin
            s = int'($urandom_range(0, 1));
            e = int'($urandom_range(40, 214));
            f = int'($urandom);
            a = {s[0], e[7:0], f[22:0]};
            s = int'($urandom_range(0, 1));
            e = int'($urandom_range(40, 214));
            f = int'($urandom);
            b = {s[0], e[7:0], f[22:0]};
            start_and_wait(a, b, p);
            check_range("rand", a, b, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
